// File: rtl/mipi_dphy_pkg.sv
// Shared D-PHY lane constants: LP line codes, byte/counter widths and the lane sequencer state encoding.
package mipi_dphy_pkg;

  localparam int unsigned LP_W   = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [LP_W-1:0] LP11 = 2'b11;
  localparam logic [LP_W-1:0] LP01 = 2'b01;
  localparam logic [LP_W-1:0] LP00 = 2'b00;
  localparam logic [LP_W-1:0] LP10 = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STOP      = 3'd1,
    ST_HS_RQST   = 3'd2,
    ST_HS_PREP   = 3'd3,
    ST_SYNC_WAIT = 3'd4,
    ST_HS_RX     = 3'd5,
    ST_ERR       = 3'd6
  } lane_state_e;

endpackage

// File: rtl/mipi_lane_align_ctrl_if.sv
// Aligner-facing and packet-facing signals of the lane sequencer; master = sequencer side.
interface mipi_lane_align_ctrl_if;
  import mipi_dphy_pkg::*;

  logic              align_valid;
  logic [BYTE_W-1:0] align_data;
  logic              align_rst_n;
  logic [BYTE_W-1:0] pkt_data;
  logic              pkt_valid;
  logic              pkt_sof;
  logic              pkt_eof;

  modport master (
    input  align_valid, align_data,
    output align_rst_n, pkt_data, pkt_valid, pkt_sof, pkt_eof
  );

  modport slave (
    output align_valid, align_data,
    input  align_rst_n, pkt_data, pkt_valid, pkt_sof, pkt_eof
  );
endinterface

// File: rtl/mipi_lp_debounce.sv
// LP line filter: a code is accepted once it has been sampled on LP_DEBOUNCE consecutive edges.
module mipi_lp_debounce
  import mipi_dphy_pkg::*;
#(
  parameter int unsigned LP_DEBOUNCE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LP_W-1:0] lp_in,
  output logic [LP_W-1:0] lp_out
);

  localparam int unsigned CW = $clog2(LP_DEBOUNCE + 1);

  logic [LP_W-1:0] cand;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;

  // run length of the current candidate, saturating at the acceptance length
  always_comb begin
    cnt_nxt = CW'(1);
    if (lp_in == cand) begin
      if (cnt == CW'(LP_DEBOUNCE)) cnt_nxt = cnt;
      else                         cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= LP00;
      cnt    <= '0;
      lp_out <= LP00;
    end else begin
      cand <= lp_in;
      cnt  <= cnt_nxt;
      if (cnt_nxt == CW'(LP_DEBOUNCE)) lp_out <= lp_in;
    end
  end

endmodule

// File: rtl/mipi_lane_align_ctrl.sv
// Per-lane HS burst sequencer: LP entry detection, aligner reset/sync wait, sof/eof packet framing.
// Optional statistics counters are built when MIPI_ALIGN_STATS_EN is defined.
module mipi_lane_align_ctrl
  import mipi_dphy_pkg::*;
#(
  parameter int unsigned LP_DEBOUNCE   = 2,
  parameter int unsigned ALIGN_RST_CYC = 4,
  parameter int unsigned SYNC_TIMEOUT  = 64
) (
  input  logic                   byte_clk,
  input  logic                   sys_rst_n,
  input  logic                   enable,
  input  logic [LP_W-1:0]        lp_state,
  mipi_lane_align_ctrl_if.master bus,
  output logic                   hs_active,
  output logic                   sync_timeout,
  output logic [CNT_W-1:0]       burst_cnt,
  output logic [CNT_W-1:0]       timeout_cnt
);

  localparam int unsigned TW = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned PW = $clog2(ALIGN_RST_CYC + 1);

  lane_state_e       state;
  logic [LP_W-1:0]   lp;
  logic [TW-1:0]     timer;
  logic [PW-1:0]     prep_cnt;
  logic [BYTE_W-1:0] hold;
  logic              hold_full;
  logic              first;
  logic              burst_done_c;
  logic              timeout_c;

  mipi_lp_debounce #(.LP_DEBOUNCE(LP_DEBOUNCE)) u_lp_debounce (
    .clk    (byte_clk),
    .rst_n  (sys_rst_n),
    .lp_in  (lp_state),
    .lp_out (lp)
  );

  // a trailing align_valid beats both the LP-11 exit and the timeout
  assign burst_done_c = enable && (state == ST_HS_RX) && !bus.align_valid && (lp == LP11);
  assign timeout_c    = enable && (state == ST_SYNC_WAIT) && !bus.align_valid &&
                        (lp != LP11) && (timer == TW'(SYNC_TIMEOUT));

  always_ff @(posedge byte_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= ST_IDLE;
      bus.align_rst_n <= 1'b0;
      bus.pkt_data    <= '0;
      bus.pkt_valid   <= 1'b0;
      bus.pkt_sof     <= 1'b0;
      bus.pkt_eof     <= 1'b0;
      hs_active       <= 1'b0;
      sync_timeout    <= 1'b0;
      timer           <= '0;
      prep_cnt        <= '0;
      hold            <= '0;
      hold_full       <= 1'b0;
      first           <= 1'b0;
    end else begin
      bus.pkt_valid <= 1'b0;
      bus.pkt_sof   <= 1'b0;
      bus.pkt_eof   <= 1'b0;
      sync_timeout  <= 1'b0;
      if (!enable) begin
        state           <= ST_IDLE;
        bus.align_rst_n <= 1'b0;
        hs_active       <= 1'b0;
        hold_full       <= 1'b0;
        first           <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            bus.align_rst_n <= 1'b0;
            if (lp == LP11) state <= ST_STOP;
          end
          ST_STOP: begin
            if (lp == LP01)                      state <= ST_HS_RQST;
            else if (lp == LP00 || lp == LP10)   state <= ST_IDLE;
          end
          ST_HS_RQST: begin
            if (lp == LP00) begin
              state           <= ST_HS_PREP;
              prep_cnt        <= '0;
              bus.align_rst_n <= 1'b0;
            end else if (lp == LP11) begin
              state <= ST_STOP;
            end else if (lp == LP10) begin
              state <= ST_IDLE;
            end
          end
          ST_HS_PREP: begin
            if (prep_cnt == PW'(ALIGN_RST_CYC - 1)) begin
              state           <= ST_SYNC_WAIT;
              bus.align_rst_n <= 1'b1;
              hs_active       <= 1'b1;
              timer           <= '0;
            end else begin
              prep_cnt <= prep_cnt + PW'(1);
            end
          end
          ST_SYNC_WAIT: begin
            if (bus.align_valid) begin
              state     <= ST_HS_RX;
              hold      <= bus.align_data;
              hold_full <= 1'b1;
              first     <= 1'b1;
            end else if (lp == LP11) begin
              state           <= ST_STOP;
              bus.align_rst_n <= 1'b0;
              hs_active       <= 1'b0;
            end else if (timeout_c) begin
              state           <= ST_ERR;
              sync_timeout    <= 1'b1;
              bus.align_rst_n <= 1'b0;
              hs_active       <= 1'b0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_HS_RX: begin
            // one-byte hold lets the last byte of the burst carry eof
            if (bus.align_valid) begin
              if (hold_full) begin
                bus.pkt_valid <= 1'b1;
                bus.pkt_sof   <= first;
                bus.pkt_data  <= hold;
                first         <= 1'b0;
              end
              hold      <= bus.align_data;
              hold_full <= 1'b1;
            end else if (burst_done_c) begin
              if (hold_full) begin
                bus.pkt_valid <= 1'b1;
                bus.pkt_sof   <= first;
                bus.pkt_eof   <= 1'b1;
                bus.pkt_data  <= hold;
              end
              hold_full       <= 1'b0;
              first           <= 1'b0;
              bus.align_rst_n <= 1'b0;
              hs_active       <= 1'b0;
              state           <= ST_STOP;
            end
          end
          ST_ERR: begin
            bus.align_rst_n <= 1'b0;
            if (lp == LP11) state <= ST_STOP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MIPI_ALIGN_STATS_EN
  always_ff @(posedge byte_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      burst_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      if (burst_done_c && burst_cnt != 16'hFFFF)  burst_cnt   <= burst_cnt + CNT_W'(1);
      if (timeout_c && timeout_cnt != 16'hFFFF)   timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end
`else
  assign burst_cnt   = '0;
  assign timeout_cnt = '0;
`endif

endmodule
